// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle carrying packet-generator traffic with NetFPGA-style tuser metadata.
interface axis_pkt_gen_if #(
    parameter int unsigned C_DATA_WIDTH  = 256,
    parameter int unsigned C_TUSER_WIDTH = 128
);
    logic                        tvalid;
    logic                        tready;
    logic [C_DATA_WIDTH-1:0]     tdata;
    logic [C_DATA_WIDTH/8-1:0]   tstrb;
    logic [C_TUSER_WIDTH-1:0]    tuser;
    logic                        tlast;

    modport master (
        output tvalid, tdata, tstrb, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/axis_pkt_gen.sv
// Programmable AXI4-Stream packet generator: counter or LFSR payload, runtime length,
// gap and destination, full tready backpressure support.
module axis_pkt_gen #(
    parameter int unsigned C_DATA_WIDTH  = 256,
    parameter int unsigned C_TUSER_WIDTH = 128,
    parameter logic [7:0]  C_SRC_PORT    = 8'h01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           cfg_len,
    input  logic [15:0]           cfg_gap,
    input  logic [31:0]           cfg_num_pkts,
    input  logic                  cfg_mode,
    input  logic [7:0]            cfg_dst_port,
    axis_pkt_gen_if.master        m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkt_sent
);
    localparam int unsigned NumBytes  = C_DATA_WIDTH / 8;
    localparam int unsigned NumLanes  = C_DATA_WIDTH / 32;
    localparam logic [15:0] BeatBytes = 16'(NumBytes);
    localparam logic [31:0] LfsrSeed  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;      // bytes remaining, including the beat on the bus
    logic [15:0] gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  dst_q, dst_d;
    logic [31:0] num_q, num_d;
    logic        mode_q, mode_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] seq_q, seq_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] pkt_sent_q, pkt_sent_d;
    logic        stop_seen_q, stop_seen_d;
    logic        done_q, done_d;

    logic        sending, accept, last_beat, run_end, new_pkt;
    logic [15:0] cfg_l;
    logic [31:0] lfsr_next, lane;
    logic [NumBytes-1:0] strb;
    logic [C_TUSER_WIDTH-1:0] user;

    assign sending   = (state_q == StSend);
    assign accept    = sending && m_axis.tready;
    assign last_beat = (rem_q <= BeatBytes);
    assign cfg_l     = (cfg_len == 16'd0) ? 16'd1 : cfg_len;
    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign run_end   = ((num_q != 32'd0) && (pkt_sent_q + 32'd1 == num_q)) || stop || stop_seen_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        dst_d       = dst_q;
        num_d       = num_q;
        mode_d      = mode_q;
        beat_d      = beat_q;
        seq_d       = seq_q;
        lfsr_d      = lfsr_q;
        pkt_sent_d  = pkt_sent_q;
        stop_seen_d = stop_seen_q;
        done_d      = 1'b0;
        new_pkt     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StSend;
                    new_pkt     = 1'b1;
                    pkt_sent_d  = 32'd0;
                    seq_d       = 16'd0;
                    beat_d      = 16'd0;
                    lfsr_d      = LfsrSeed;
                    num_d       = cfg_num_pkts;
                    mode_d      = cfg_mode;
                    stop_seen_d = 1'b0;
                end
            end
            StSend: begin
                if (stop) stop_seen_d = 1'b1;
                if (accept) begin
                    lfsr_d = lfsr_next;
                    if (last_beat) begin
                        beat_d = 16'd0;
                        seq_d  = seq_q + 16'd1;
                        if (pkt_sent_q != 32'hFFFF_FFFF) pkt_sent_d = pkt_sent_q + 32'd1;
                        if (run_end) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (gap_q == 16'd0) begin
                            new_pkt = 1'b1;
                        end else begin
                            state_d   = StGap;
                            gap_cnt_d = gap_q - 16'd1;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                        rem_d  = rem_q - BeatBytes;
                    end
                end
            end
            StGap: begin
                if (stop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == 16'd0) begin
                    state_d = StSend;
                    new_pkt = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Per-packet configuration is captured as the packet's first beat goes on the bus.
        if (new_pkt) begin
            len_d = cfg_l;
            rem_d = cfg_l;
            gap_d = cfg_gap;
            dst_d = cfg_dst_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= 16'd0;
            rem_q       <= 16'd0;
            gap_q       <= 16'd0;
            gap_cnt_q   <= 16'd0;
            dst_q       <= 8'd0;
            num_q       <= 32'd0;
            mode_q      <= 1'b0;
            beat_q      <= 16'd0;
            seq_q       <= 16'd0;
            lfsr_q      <= LfsrSeed;
            pkt_sent_q  <= 32'd0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            dst_q       <= dst_d;
            num_q       <= num_d;
            mode_q      <= mode_d;
            beat_q      <= beat_d;
            seq_q       <= seq_d;
            lfsr_q      <= lfsr_d;
            pkt_sent_q  <= pkt_sent_d;
            stop_seen_q <= stop_seen_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        lane = mode_q ? lfsr_q : {seq_q, beat_q};
        for (int unsigned i = 0; i < NumBytes; i++) begin
            strb[i] = !last_beat || (i < 32'(rem_q));
        end
        user        = '0;
        user[15:0]  = len_q;
        user[23:16] = C_SRC_PORT;
        user[31:24] = dst_q;
    end

    // Outputs are forced to zero outside SEND so idle and reset values are all-zero.
    assign m_axis.tvalid = sending;
    assign m_axis.tlast  = sending && last_beat;
    assign m_axis.tdata  = sending ? {NumLanes{lane}} : '0;
    assign m_axis.tstrb  = sending ? strb : '0;
    assign m_axis.tuser  = sending ? user : '0;

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign pkt_sent = pkt_sent_q;
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: a packet-level model checks every presented beat, and
// hand-computed literals pin lengths, strobes, gaps, LFSR values and run control.
module tb_axis_pkt_gen;
    localparam int W = 256;
    localparam int U = 128;
    localparam int B = W / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] cfg_len = 16'd0;
    logic [15:0] cfg_gap = 16'd0;
    logic [31:0] cfg_num_pkts = 32'd0;
    logic        cfg_mode = 1'b0;
    logic [7:0]  cfg_dst_port = 8'd0;
    logic        busy, done;
    logic [31:0] pkt_sent;

    axis_pkt_gen_if #(.C_DATA_WIDTH(W), .C_TUSER_WIDTH(U)) axis ();

    axis_pkt_gen #(.C_DATA_WIDTH(W), .C_TUSER_WIDTH(U), .C_SRC_PORT(8'h01)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .cfg_len      (cfg_len),
        .cfg_gap      (cfg_gap),
        .cfg_num_pkts (cfg_num_pkts),
        .cfg_mode     (cfg_mode),
        .cfg_dst_port (cfg_dst_port),
        .m_axis       (axis),
        .busy         (busy),
        .done         (done),
        .pkt_sent     (pkt_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    // Model state: position within the run as seen from the consumer side.
    bit [15:0]   m_seq, m_beat;
    logic [31:0] m_lfsr;
    bit          p_stall;

    int cyc = 0, nacc, low_run, done_cyc, first_valid, nsamp;
    logic [31:0] a_strb[$];
    logic [31:0] a_lane[$];
    bit          a_last[$];
    logic [15:0] a_len[$];
    int          a_cyc[$];
    int          gaps[$];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], ^(s & 32'h8020_0003)};
    endfunction

    task automatic sample();
        int L, n, r;
        logic [31:0] lane, es;
        logic [U-1:0] eu;
        if (p_stall) chk("tvalid_hold", axis.tvalid, 1);
        if (nsamp == 0) first_valid = axis.tvalid;
        nsamp++;
        if (done) done_cyc = cyc;
        if (axis.tvalid) begin
            if (low_run > 0 && nacc > 0) gaps.push_back(low_run);
            low_run = 0;
            L  = (cfg_len == 16'd0) ? 1 : int'(cfg_len);
            n  = (L + B - 1) / B;
            r  = L % B;
            lane = cfg_mode ? m_lfsr : {m_seq, m_beat};
            es = (int'(m_beat) == n - 1 && r != 0) ? (32'hFFFF_FFFF >> (B - r)) : 32'hFFFF_FFFF;
            eu = '0;
            eu[15:0]  = 16'(L);
            eu[23:16] = 8'h01;
            eu[31:24] = cfg_dst_port;
            chk("tdata", axis.tdata, {8{lane}});
            chk("tstrb", axis.tstrb, es);
            chk("tuser", axis.tuser, eu);
            chk("tlast", axis.tlast, int'(m_beat) == n - 1);
            if (axis.tready) begin
                a_strb.push_back(axis.tstrb);
                a_lane.push_back(axis.tdata[31:0]);
                a_last.push_back(axis.tlast);
                a_len.push_back(axis.tuser[15:0]);
                a_cyc.push_back(cyc);
                nacc++;
                m_lfsr = lfsr_step(m_lfsr);
                if (int'(m_beat) == n - 1) begin
                    m_beat = 0;
                    m_seq++;
                end else begin
                    m_beat++;
                end
            end
        end else if (busy) begin
            low_run++;
        end
        p_stall = axis.tvalid && !axis.tready;
    endtask

    // Sample on the falling edge, then return just after the next rising edge for driving.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset) p_stall = 0;
        else sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        a_strb.delete(); a_lane.delete(); a_last.delete();
        a_len.delete();  a_cyc.delete();  gaps.delete();
        nacc = 0; low_run = 0; done_cyc = -1; nsamp = 0; first_valid = 0;
    endtask

    task automatic do_start();
        m_seq = 0; m_beat = 0; m_lfsr = 32'hFFFF_FFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        clear_rec();
    endtask

    // rmode: 0 ready always, 1 random ready, 2 ready low for `hold` cycles then high.
    task automatic run(input int budget, input int rmode, input int hold, input int stop_at,
                       input int brk, input bit pulse_start);
        int k = 0;
        while (done_cyc < 0 && (brk < 0 || nacc < brk) && k < budget) begin
            case (rmode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = 1'($urandom_range(0, 1));
                default: axis.tready = (k >= hold);
            endcase
            if (stop_at >= 0 && nacc >= stop_at) stop = 1'b1;
            start = pulse_start && (nacc == 5 || nacc == 13);
            step();
            k++;
        end
        start = 1'b0;
        stop  = 1'b0;
        chk("run_in_budget", k < budget, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, axis.tvalid, 0);
        chk({tag, "_tlast"}, axis.tlast, 0);
        chk({tag, "_tdata"}, axis.tdata, 0);
        chk({tag, "_tstrb"}, axis.tstrb, 0);
        chk({tag, "_tuser"}, axis.tuser, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pkt_sent"}, pkt_sent, 0);
    endtask

    initial begin
        axis.tready = 1'b1;
        m_lfsr = 32'hFFFF_FFFF;
        clear_rec();
        repeat (3) step();
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Length 100 on a 32-byte bus: 4 beats, last beat has 4 valid bytes.
        cfg_len = 16'd100; cfg_gap = 16'd0; cfg_num_pkts = 32'd1; cfg_mode = 1'b0;
        cfg_dst_port = 8'h5A;
        do_start();
        run(50, 0, 0, -1, -1, 0);
        chk("t1_first_valid", first_valid, 1);
        chk("t1_beats", a_strb.size(), 4);
        chk("t1_strb0", a_strb[0], 32'hFFFF_FFFF);
        chk("t1_strb3", a_strb[3], 32'h0000_000F);
        chk("t1_last2", a_last[2], 0);
        chk("t1_last3", a_last[3], 1);
        chk("t1_len", a_len[0], 16'd100);
        chk("t1_done_time", done_cyc, a_cyc[3] + 1);
        chk("t1_pkt_sent", pkt_sent, 1);
        chk("t1_busy", busy, 0);

        // Fresh reset, then ready held low for 100 ns from reset release.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        axis.tready = 1'b0;
        cfg_len = 16'd64; cfg_num_pkts = 32'd1;
        do_start();
        run(60, 2, 9, -1, -1, 0);
        chk("t2_first_valid", first_valid, 1);
        chk("t2_beats", a_lane.size(), 2);
        chk("t2_lane0", a_lane[0], 32'h0000_0000);
        chk("t2_lane1", a_lane[1], 32'h0000_0001);
        chk("t2_pkt_sent", pkt_sent, 1);

        // Exact multiple with a 5-cycle gap, three packets.
        cfg_len = 16'd64; cfg_gap = 16'd5; cfg_num_pkts = 32'd3;
        do_start();
        run(100, 0, 0, -1, -1, 0);
        chk("t3_beats", a_lane.size(), 6);
        chk("t3_strb1", a_strb[1], 32'hFFFF_FFFF);
        chk("t3_last1", a_last[1], 1);
        chk("t3_ngaps", gaps.size(), 2);
        chk("t3_gap0", gaps[0], 5);
        chk("t3_gap1", gaps[1], 5);
        chk("t3_lane_p2b1", a_lane[5], 32'h0002_0001);
        chk("t3_pkt_sent", pkt_sent, 3);

        // LFSR payload under random backpressure.
        cfg_len = 16'd96; cfg_gap = 16'd0; cfg_num_pkts = 32'd2; cfg_mode = 1'b1;
        do_start();
        run(300, 1, 0, -1, -1, 0);
        chk("t4_beats", a_lane.size(), 6);
        chk("t4_lfsr0", a_lane[0], 32'hFFFF_FFFF);
        chk("t4_lfsr1", a_lane[1], 32'hFFFF_FFFE);
        chk("t4_lfsr2", a_lane[2], 32'hFFFF_FFFD);
        chk("t4_lfsr3", a_lane[3], 32'hFFFF_FFFB);
        chk("t4_pkt_sent", pkt_sent, 2);

        // Endless run stopped inside packet 10; start pulses while busy must be ignored.
        cfg_len = 16'd40; cfg_num_pkts = 32'd0; cfg_mode = 1'b0; cfg_dst_port = 8'h33;
        do_start();
        run(200, 0, 0, 21, -1, 1);
        chk("t5_beats", a_lane.size(), 22);
        chk("t5_last", a_last[21], 1);
        chk("t5_lane", a_lane[21], 32'h000A_0001);
        chk("t5_done_time", done_cyc, a_cyc[21] + 1);
        chk("t5_pkt_sent", pkt_sent, 11);

        // Zero length clamps to a single one-byte beat.
        cfg_len = 16'd0; cfg_num_pkts = 32'd1;
        do_start();
        run(20, 0, 0, -1, -1, 0);
        chk("t5z_beats", a_strb.size(), 1);
        chk("t5z_strb", a_strb[0], 32'h0000_0001);
        chk("t5z_last", a_last[0], 1);
        chk("t5z_len", a_len[0], 16'd1);

        // Reset while beat 2 of 4 is on the bus, then a clean restart.
        cfg_len = 16'd128; cfg_num_pkts = 32'd1;
        do_start();
        run(50, 0, 0, -1, 2, 0);
        reset = 1'b1;
        step();
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        do_start();
        run(50, 0, 0, -1, -1, 0);
        chk("t6_beats", a_lane.size(), 4);
        chk("t6_lane0", a_lane[0], 32'h0000_0000);
        chk("t6_lane3", a_lane[3], 32'h0000_0003);
        chk("t6_last3", a_last[3], 1);
        chk("t6_pkt_sent", pkt_sent, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

Parametrised AXI4-Stream packet generator that replaces the fixed-pattern traffic source used to exercise the SRAM output-queue datapath. It emits a programmable number of packets with runtime length, inter-packet gap, destination port and payload pattern. Output beats carry NetFPGA-style `tuser` metadata. The block fully honours `tready` backpressure and sits directly in front of the output-queue slave port in benches and in hardware self-test builds.

## Interface
- `C_DATA_WIDTH`, default 256: `tdata` width in bits. Must be a multiple of 32 and at least 64.
- `C_TUSER_WIDTH`, default 128: `tuser` width in bits. Must be at least 32.
- `C_SRC_PORT`, default 8'h01: constant written to `tuser[23:16]`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse that begins a run. Sampled only in IDLE.
- `stop` in 1: level; ends the run after the current packet.
- `cfg_len` in 16: packet length in bytes. Latched at the first beat of each packet.
- `cfg_gap` in 16: idle cycles between packets. Latched at the same point as `cfg_len`.
- `cfg_num_pkts` in 32: packets per run; 0 means run forever. Latched at `start`.
- `cfg_mode` in 1: payload pattern; 0 = counter, 1 = LFSR. Latched at `start`.
- `cfg_dst_port` in 8: written to `tuser[31:24]`. Latched per packet.
- `tvalid` out 1: AXI-Stream valid.
- `tready` in 1: AXI-Stream ready.
- `tdata` out `C_DATA_WIDTH`: payload.
- `tstrb` out `C_DATA_WIDTH/8`: byte strobes.
- `tuser` out `C_TUSER_WIDTH`: packet metadata.
- `tlast` out 1: last beat of a packet.
- `busy` out 1: high whenever the block is not in IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `pkt_sent` out 32: count of fully accepted packets since `start`.

## Operation
- Definitions: B = `C_DATA_WIDTH/8`; L = latched `cfg_len`, with 0 clamped to 1; beats per packet N = ceil(L/B).
- States:
  - IDLE → SEND on `start`. This clears `pkt_sent`, the beat index and the packet sequence number.
  - SEND → SEND on acceptance of the last beat when the run continues and gap = 0, giving back-to-back packets.
  - SEND → GAP on acceptance of the last beat when the run continues and gap > 0.
  - GAP → SEND after exactly gap cycles.
  - SEND → IDLE on acceptance of the last beat when the run ends.
- A run ends when either condition holds:
  - `cfg_num_pkts` ≠ 0 and `pkt_sent`+1 equals `cfg_num_pkts`;
  - `stop` is high on the cycle the last beat is accepted, or was high at any cycle since the packet started (sticky flag, cleared at `start`).
- `stop` sampled in GAP: the block goes straight to IDLE and pulses `done`.
- `start` while `busy`: ignored.
- Beat acceptance is `tvalid && tready`. The beat index increments on each accepted beat and resets to 0 after the last beat.
- `tlast` = 1 when beat index = N-1.
- `tstrb`:
  - all ones on non-last beats;
  - on the last beat, the low (L mod B) bits are ones and the rest zero;
  - if L mod B = 0, all ones.
- `tuser`:
  - [15:0] = L, [23:16] = `C_SRC_PORT`, [31:24] = latched dst port;
  - upper bits are 0;
  - the value is held for every beat of the packet.
- Payload, mode 0: every 32-bit lane = {seq[15:0], beat_idx[15:0]}, where seq is the packet sequence number mod 2^16 and wraps freely.
- Payload, mode 1: 32-bit Fibonacci LFSR x^32+x^22+x^2+x+1, replicated into every lane.
  - Seed 32'hFFFFFFFF on reset and on `start`.
  - Advances once per accepted beat.
- Bytes above L in the last beat still carry pattern data; consumers must rely on `tstrb`.
- `pkt_sent` saturates at 2^32-1.

## Timing
- Reset values: `tvalid`, `tlast`, `busy`, `done` = 0; `tdata`, `tstrb`, `tuser`, `pkt_sent` = 0; state = IDLE.
- Reset mid-packet: `tvalid` is 0 on the next cycle and the packet is truncated with no `tlast`; this is intended.
- `start` sampled high in cycle t gives `tvalid`=1 in cycle t+1 with beat 0 presented.
- `tvalid` never drops while `tready`=0.
- `tdata`, `tstrb`, `tuser` and `tlast` are stable from `tvalid` rising until acceptance.
- Gap: last beat accepted in cycle t gives the next first beat with `tvalid` high in cycle t+gap+1. With gap = 0, `tvalid` stays high continuously.
- `done` is asserted in the cycle after the final acceptance, coincident with `busy` falling.
- `pkt_sent` is updated in the cycle after the last-beat acceptance.

## Test plan
- Length and strobes: W=256, len=100, gap=0, num=1, `tready`=1 → exactly 4 beats; `tstrb` = 32'hFFFFFFFF ×3, then 32'h0000000F with `tlast`=1; `tuser[15:0]`=100; `done` one cycle later; `pkt_sent`=1.
- Reset during backpressure: `tready`=0 for the first 100 ns after reset release, then 1 → `tvalid` high from the cycle after `start`; beat 0 data unchanged until accepted; no beat lost or duplicated.
- Exact multiple and gap: len=64, gap=5, num=3 → 2 beats per packet, the last with all-ones `tstrb`; exactly 5 `tvalid`-low cycles between packets; mode 0 lane on packet 2, beat 1 = 32'h00020001.
- LFSR sequence: mode 1, len=96, num=2 with random `tready` toggling → 6 accepted beats whose lane values match the reference LFSR sequence from seed FFFFFFFF; LFSR does not advance on stalled beats.
- Stop and wraparound: num=0 and `stop` asserted mid-packet 10 → packet 10 completes with `tlast`; `done` pulses; `pkt_sent`=11; `start` pulses while busy have no effect; len=0 gives 1 beat with `tstrb`=1.
- Reset mid-packet: assert `reset` on beat 2 of 4 → all outputs 0 next cycle; a new `start` then produces a clean packet from beat 0 with seq=0.
